// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {REQ, BUF, DROP} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetch that ID could not accept.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  ifid_entry_t d,
    output ifid_entry_t q,
    output logic        valid
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, imem req/ack fetch, skid buffering and redirects feeding IF/ID.
// Optional MISALIGN_TRAP_EN adds misalign_o, pulsed after a redirect to a non-word-aligned target.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            id_stall_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);
    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, addr_n, target;
    ifid_entry_t     ifid, ifid_n, fetched, skid_q;
    logic            ifid_valid_n, skid_load, skid_clear, skid_valid, acc, can_acc;

    assign acc     = imem_req_o & imem_ack_i;
    assign can_acc = ~ifid_valid_o | ~id_stall_i;
    assign target  = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign fetched = '{instr: imem_rdata_i, pc: imem_addr_o, pc4: pc_plus4_i};

    fetch_skid_buf u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (fetched),
        .q     (skid_q),
        .valid (skid_valid)
    );

    always_comb begin
        state_n      = state;
        pc_n         = pc_o;
        addr_n       = imem_addr_o;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        // ID takes the current entry this edge unless something refills it
        ifid_n       = can_acc ? '0 : ifid;
        ifid_valid_n = can_acc ? 1'b0 : ifid_valid_o;
        if (redirect_i) begin
            pc_n         = target;
            ifid_n       = '0;
            ifid_valid_n = 1'b0;
            skid_clear   = 1'b1;
            // an unacked request must finish at its old address before retargeting
            if (state == DROP || (state == REQ && imem_req_o)) begin
                state_n = acc ? REQ : DROP;
                addr_n  = acc ? target : imem_addr_o;
            end else begin
                state_n = REQ;
                addr_n  = target;
            end
        end else if (state == REQ) begin
            if (acc) begin
                pc_n = pc_plus4_i;
                if (can_acc) begin
                    ifid_n       = fetched;
                    ifid_valid_n = 1'b1;
                    addr_n       = pc_plus4_i;
                end else begin
                    skid_load = 1'b1;
                    state_n   = BUF;
                end
            end
        end else if (state == BUF) begin
            if (!id_stall_i) begin
                ifid_n       = skid_q;
                ifid_valid_n = skid_valid;
                addr_n       = pc_o;
                state_n      = REQ;
            end
        end else if (acc) begin
            addr_n  = pc_o;
            state_n = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= REQ;
            pc_o         <= RESET_PC;
            imem_addr_o  <= RESET_PC;
            imem_req_o   <= 1'b0;
            ifid         <= '0;
            ifid_valid_o <= 1'b0;
        end else begin
            state        <= state_n;
            pc_o         <= pc_n;
            imem_addr_o  <= addr_n;
            imem_req_o   <= state_n != BUF;
            ifid         <= ifid_n;
            ifid_valid_o <= ifid_valid_n;
        end
    end

    assign ifid_instr_o = ifid.instr;
    assign ifid_pc_o    = ifid.pc;
    assign ifid_pc4_o   = ifid.pc4;

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        misalign_o <= reset ? 1'b0 : redirect_i & |redirect_pc_i[1:0];
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios then random traffic checked against a program-order model.
module tb_if_fetch_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] pc, pc_plus4, redirect_pc = '0, imem_addr, imem_rdata;
    logic        redirect = 1'b0, imem_req, imem_ack = 1'b0, id_stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign pc_plus4   = pc + fetch_pkg::PC_STEP;

    if_fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_o          (pc),
        .pc_plus4_i    (pc_plus4),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .id_stall_i    (id_stall),
        .ifid_valid_o  (ifid_valid),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] p);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
        chk({tag, ".pc"}, ifid_pc, p);
        chk({tag, ".pc4"}, ifid_pc4, p + 32'd4);
        chk({tag, ".instr"}, ifid_instr, mem_word(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc, prev_addr;
    logic        prev_pend, exp_mis;
    int          consumed;

    initial begin
        tick(); tick();
        chk("rst.pc", pc, 32'h40);
        chk("rst.addr", imem_addr, 32'h40);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst.instr", ifid_instr, 32'd0);
        chk("rst.ifid_pc", ifid_pc, 32'd0);
        chk("rst.ifid_pc4", ifid_pc4, 32'd0);
        reset = 1'b0; imem_ack = 1'b1;
        tick();
        chk("first.req", {31'd0, imem_req}, 32'd1);
        chk("first.addr", imem_addr, 32'h40);
        tick(); chk_entry("seq0", 32'h40);
        tick(); chk_entry("seq1", 32'h44);
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_entry("stall.hold", 32'h44);
            chk("stall.req", {31'd0, imem_req}, 32'd0);
        end
        id_stall = 1'b0;
        tick(); chk_entry("skid.out", 32'h48);
        chk("skid.addr", imem_addr, 32'h4C);
        tick(); chk_entry("after.skid", 32'h4C);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("drop.valid", {31'd0, ifid_valid}, 32'd0);
        chk("drop.pc", pc, 32'h100);
        chk("drop.addr_hold", imem_addr, 32'h50);
        tick();
        chk("drop.wait", imem_addr, 32'h50);
        imem_ack = 1'b1;
        tick();
        chk("drop.discard", {31'd0, ifid_valid}, 32'd0);
        chk("drop.newaddr", imem_addr, 32'h100);
        tick(); chk_entry("redir.first", 32'h100);
        id_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        id_stall = 1'b0; redirect = 1'b0;
        chk("rs.valid", {31'd0, ifid_valid}, 32'd0);
        chk("rs.instr", ifid_instr, 32'd0);
        chk("rs.pc", pc, 32'h100);
        tick(); chk_entry("rs.next", 32'h100);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFF8);
        tick(); chk_entry("wrap0", 32'hFFFF_FFF8);
        tick(); chk_entry("wrap1", 32'hFFFF_FFFC);
        tick(); chk_entry("wrap2", 32'h0);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("mis.pc", pc, 32'h100);
        chk("mis.addr", imem_addr, 32'h100);
`ifdef MISALIGN_TRAP_EN
        chk("mis.pulse", {31'd0, misalign}, 32'd1);
`endif
        tick(); chk_entry("mis.fetch", 32'h100);
`ifdef MISALIGN_TRAP_EN
        chk("mis.clear", {31'd0, misalign}, 32'd0);
`endif
        imem_ack = 1'b0; reset = 1'b1;
        tick();
        chk("mrst.req", {31'd0, imem_req}, 32'd0);
        chk("mrst.valid", {31'd0, ifid_valid}, 32'd0);
        chk("mrst.pc", pc, 32'h40);
        reset = 1'b0; imem_ack = 1'b1;
        tick();
        chk("late_ack.valid", {31'd0, ifid_valid}, 32'd0);
        chk("late_ack.req", {31'd0, imem_req}, 32'd1);
        chk("late_ack.addr", imem_addr, 32'h40);
        tick(); chk_entry("mrst.first", 32'h40);

        exp_pc = 32'h40;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            id_stall    = $urandom_range(0, 9) < 3;
            imem_ack    = $urandom_range(0, 9) < 6;
            redirect    = $urandom_range(0, 29) == 0;
            redirect_pc = $urandom;
            if (!ifid_valid) chk("rnd.nop", ifid_instr, 32'd0);
            if (ifid_valid && !id_stall && !redirect) begin
                chk("rnd.pc", ifid_pc, exp_pc);
                chk("rnd.pc4", ifid_pc4, exp_pc + 32'd4);
                chk("rnd.instr", ifid_instr, mem_word(exp_pc));
                exp_pc += 32'd4;
                consumed++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'd3;
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            exp_mis   = redirect && (redirect_pc[1:0] != 2'b00);
            tick();
            if (prev_pend) begin
                chk("rnd.req_hold", {31'd0, imem_req}, 32'd1);
                chk("rnd.addr_hold", imem_addr, prev_addr);
            end
`ifdef MISALIGN_TRAP_EN
            chk("rnd.misalign", {31'd0, misalign}, {31'd0, exp_mis});
`endif
        end
        chk("rnd.progress", {31'd0, consumed > 200}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the CPU pipeline. It owns the PC register and drives it to the datapath's 32-bit ripple adder (S=pc_o, G tied to 32'd4), then consumes the adder's sum as the sequential next PC.
- It issues req/ack fetches to instruction memory, absorbs ID-stage stalls with a one-entry skid buffer, and applies branch/jump redirects from EX.
- It produces the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC and first fetch address after reset
- XLEN, 32, address/instruction width; only 32 is supported

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- pc_o  out  XLEN  current PC register; drives adder S input
- pc_plus4_i  in  XLEN  adder sum (pc_o+4); combinational from pc_o, settles within one cycle
- redirect_i  in  1  taken branch/jump from EX; 1-cycle pulse
- redirect_pc_i  in  XLEN  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address; stable while imem_req_o=1
- imem_ack_i  in  1  data valid; accepted only while imem_req_o=1
- imem_rdata_i  in  XLEN  fetched instruction
- id_stall_i  in  1  ID cannot accept a new IF/ID entry
- ifid_valid_o  out  1  IF/ID entry valid
- ifid_instr_o  out  XLEN  instruction (NOP=0 when invalid)
- ifid_pc_o  out  XLEN  PC of the instruction
- ifid_pc4_o  out  XLEN  PC+4 of the instruction

Behaviour:
- Reset (sync, high), all registered:
  - pc_o=RESET_PC, imem_addr_o=RESET_PC, imem_req_o=0
  - ifid_valid_o=0; ifid_instr_o, ifid_pc_o, ifid_pc4_o all 0
  - skid buffer empty; state=REQ
  - Reset asserted mid-transaction abandons any outstanding request; a late ack arriving after reset is ignored while req=0.
- imem_req_o=1 in REQ and DROP, 0 in BUF and during reset.
- Req/addr rule: once asserted, imem_req_o and imem_addr_o hold until the ack cycle.
- IF/ID "can accept": ~ifid_valid_o | ~id_stall_i.
- REQ:
  - ack and can accept: load IF/ID={rdata, imem_addr_o, pc_plus4_i}, valid=1; pc<=pc_plus4_i; imem_addr<=pc_plus4_i; stay REQ. This gives back-to-back fetches, 1 instr/cycle with zero-wait memory.
  - ack and cannot accept: capture into skid buffer; pc<=pc_plus4_i; go BUF.
  - no ack: hold.
- BUF: when ~id_stall_i, move skid buffer into IF/ID (valid=1), imem_addr<=pc_o, go REQ.
- DROP (redirect occurred while a request was outstanding): keep req/addr unchanged; on ack discard rdata, imem_addr<=pc_o, go REQ.
- Stall: while ifid_valid_o & id_stall_i, all IF/ID fields hold.
- Redirect: highest priority, over stall, ack and skid contents.
  - pc<=redirect_pc_i with [1:0] forced to 0.
  - ifid_valid_o<=0, ifid_instr_o<=0, skid buffer cleared.
  - From REQ: with same-cycle ack, discard data, imem_addr<=new pc, stay REQ; without ack, go DROP.
  - From BUF: go REQ with new address.
  - From DROP: latest target wins, stay DROP.
- Latency: IF/ID valid the cycle after the ack edge; redirect to first new request issue is 1 cycle (zero-wait case).
- PC wraps naturally: 32'hFFFF_FFFC+4=0 (adder carry-out dropped).

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - adds port misalign_o (out, 1).
  - It pulses 1 for one cycle after any redirect whose redirect_pc_i[1:0]!=0, reset value 0.
  - The PC is still aligned by clearing bits [1:0].
- Not defined: no port; low bits are silently cleared.

Decomposition:
- Package fetch_pkg:
  - state enum {REQ, BUF, DROP}, 2-bit encoding
  - NOP_INSTR=32'h0000_0000
  - PC_STEP=32'd4 (tie-off for the adder G input)
  - IF/ID entry struct {instr, pc, pc4}
- Sub-module fetch_skid_buf: one-entry holding register with load/clear/valid.
- The adder stays external: instantiated at the top level, not inside this block.

Test Plan:
- Reset with RESET_PC=32'h0000_0040 and zero-wait ack → first request addr 0x40; IF/ID pcs 0x40, 0x44, 0x48 on consecutive cycles, valid=1 each cycle.
- id_stall_i=1 for 3 cycles with ack always high → IF/ID holds 0x44; skid holds 0x48; req low during stall; after release, 0x48 then 0x4C issued.
- Redirect to 0x100 while ack waits 2 cycles → DROP; the old ack's data never becomes valid; next request addr=0x100.
- Redirect and stall in the same cycle with IF/ID valid → ifid_valid_o=0 next cycle, pc_o=0x100.
- Start at 0xFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- MISALIGN_TRAP_EN, redirect to 0x103 → misalign_o=1 for one cycle; next fetch at 0x100.
